// File: rtl/ula_operand_loader_pkg.sv
// ula_operand_loader_pkg
//   Shared definitions for the ALU operand loader slice.
//   - state_t   : sequencer states (GET_A, GET_B, GET_OP, EXEC, SHOW)
//   - ULA_OP_W  : operand/opcode width seen by the ALU
//   - ULA_RES_W : ALU result width
//   - OP_*      : ALU opcode constants (ADD..XOR)
//   - step_for  : one-hot step LED pattern for a given state
package ula_operand_loader_pkg;

  localparam int ULA_OP_W  = 3;
  localparam int ULA_RES_W = 6;

  typedef enum logic [2:0] {
    ST_GET_A  = 3'd0,
    ST_GET_B  = 3'd1,
    ST_GET_OP = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SHOW   = 3'd4
  } state_t;

  localparam logic [ULA_OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [ULA_OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [ULA_OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [ULA_OP_W-1:0] OP_DIV = 3'd3;
  localparam logic [ULA_OP_W-1:0] OP_AND = 3'd4;
  localparam logic [ULA_OP_W-1:0] OP_OR  = 3'd5;
  localparam logic [ULA_OP_W-1:0] OP_XOR = 3'd6;

  // Step LEDs light only while the operator is expected to enter something.
  function automatic logic [2:0] step_for(state_t s);
    case (s)
      ST_GET_A:  return 3'b001;
      ST_GET_B:  return 3'b010;
      ST_GET_OP: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ula_operand_loader_if.sv
// ula_operand_loader_if
//   Bundles the board-side and ALU-side signals of the operand loader.
//   slave  : the loader's view (takes switches, buttons, ALU result; drives operands, latches, LEDs)
//   master : the board/ALU view (the opposite directions)
//   sw, btn_enter, btn_clear      : raw board inputs
//   result_in, zero_in, neg_in, ovf_in : combinational ALU outputs
//   a, b, op                      : registered ALU operands/opcode
//   result_q, zero_q, neg_q, ovf_q: latched result and flags for display
//   done                          : one-cycle pulse when the latches update
//   step                          : one-hot step LEDs
interface ula_operand_loader_if;
  import ula_operand_loader_pkg::*;

  logic [ULA_OP_W-1:0]  sw;
  logic                 btn_enter;
  logic                 btn_clear;
  logic [ULA_RES_W-1:0] result_in;
  logic                 zero_in;
  logic                 neg_in;
  logic                 ovf_in;
  logic [ULA_OP_W-1:0]  a;
  logic [ULA_OP_W-1:0]  b;
  logic [ULA_OP_W-1:0]  op;
  logic [ULA_RES_W-1:0] result_q;
  logic                 zero_q;
  logic                 neg_q;
  logic                 ovf_q;
  logic                 done;
  logic [2:0]           step;

  modport master (
    output sw, btn_enter, btn_clear, result_in, zero_in, neg_in, ovf_in,
    input  a, b, op, result_q, zero_q, neg_q, ovf_q, done, step
  );

  modport slave (
    input  sw, btn_enter, btn_clear, result_in, zero_in, neg_in, ovf_in,
    output a, b, op, result_q, zero_q, neg_q, ovf_q, done, step
  );

endinterface

// File: rtl/ula_operand_loader_btn_debounce.sv
// btn_debounce
//   Turns a raw asynchronous push button into a single-cycle press pulse:
//   2-flop synchronizer -> debounce -> rising-edge detect.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   btn   : raw button level, active-high
//   press : one-cycle pulse when a new high level is accepted
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // The counter tracks how many consecutive cycles the synchronized input has
  // disagreed with the accepted level; any agreement restarts it. The press
  // pulse is raised in the same step that accepts a new high level, so a held
  // button produces exactly one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      press  <= 1'b0;
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST_CNT) begin
        level <= sync_q[1];
        cnt   <= '0;
        press <= sync_q[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ula_operand_loader.sv
// ula_operand_loader
//   Sequences operand entry for the combinational 3-bit ALU: A, then B, then
//   OP from the switches (each confirmed with ENTER), then latches the ALU
//   result and flags one cycle later and holds them for display.
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : ula_operand_loader_if.slave (switches, buttons, ALU I/O, LEDs)
module ula_operand_loader
  import ula_operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input logic                 clk,
  input logic                 rst,
  ula_operand_loader_if.slave bus
);

  logic enter_press;
  logic clear_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_enter),
    .press (enter_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_clear),
    .press (clear_press)
  );

  state_t               state;
  logic [ULA_OP_W-1:0]  a_q;
  logic [ULA_OP_W-1:0]  b_q;
  logic [ULA_OP_W-1:0]  op_q;
  logic [ULA_RES_W-1:0] result_q;
  logic                 zero_q;
  logic                 neg_q;
  logic                 ovf_q;
  logic                 done_q;
  logic [2:0]           step_q;

  // Single sequencer with registered outputs. CLEAR is checked before the
  // state case so it beats a simultaneous ENTER. EXEC ignores ENTER and moves
  // on by itself, giving the ALU one full cycle with stable operands before
  // its outputs are latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_GET_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      step_q   <= step_for(ST_GET_A);
    end else begin
      done_q <= 1'b0;
      if (clear_press) begin
        state    <= ST_GET_A;
        a_q      <= '0;
        b_q      <= '0;
        op_q     <= '0;
        result_q <= '0;
        zero_q   <= 1'b0;
        neg_q    <= 1'b0;
        ovf_q    <= 1'b0;
        step_q   <= step_for(ST_GET_A);
      end else begin
        case (state)
          ST_GET_A: begin
            if (enter_press) begin
              a_q    <= bus.sw;
              state  <= ST_GET_B;
              step_q <= step_for(ST_GET_B);
            end
          end
          ST_GET_B: begin
            if (enter_press) begin
              b_q    <= bus.sw;
              state  <= ST_GET_OP;
              step_q <= step_for(ST_GET_OP);
            end
          end
          ST_GET_OP: begin
            if (enter_press) begin
              op_q   <= bus.sw;
              state  <= ST_EXEC;
              step_q <= step_for(ST_EXEC);
            end
          end
          ST_EXEC: begin
            result_q <= bus.result_in;
            zero_q   <= bus.zero_in;
            neg_q    <= bus.neg_in;
            ovf_q    <= bus.ovf_in;
            done_q   <= 1'b1;
            state    <= ST_SHOW;
            step_q   <= step_for(ST_SHOW);
          end
          ST_SHOW: begin
            // A new A starts the next operation; the shown result stays put.
            if (enter_press) begin
              a_q    <= bus.sw;
              state  <= ST_GET_B;
              step_q <= step_for(ST_GET_B);
            end
          end
          default: begin
            state  <= ST_GET_A;
            step_q <= step_for(ST_GET_A);
          end
        endcase
      end
    end
  end

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.op       = op_q;
  assign bus.result_q = result_q;
  assign bus.zero_q   = zero_q;
  assign bus.neg_q    = neg_q;
  assign bus.ovf_q    = ovf_q;
  assign bus.done     = done_q;
  assign bus.step     = step_q;

endmodule

// File: tb/tb_ula_operand_loader.sv
// tb_ula_operand_loader
//   Directed bench for ula_operand_loader with a behavioural 3-bit ALU wired
//   to A/B/OP. Expected results are queued when an operation is issued and
//   popped when DONE pulses.
module tb_ula_operand_loader;
  import ula_operand_loader_pkg::*;

  typedef struct packed {
    logic [5:0] result;
    logic       zero;
    logic       neg;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ula_operand_loader_if bus ();

  ula_operand_loader #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Board ALU: unsigned 6-bit result, divide-by-zero flagged as overflow,
  // negative reported as the sign bit of the 3-bit signed view of the result.
  logic [5:0] alu_r;
  logic       alu_ovf;

  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      OP_ADD: alu_r = {3'b000, bus.a} + {3'b000, bus.b};
      OP_SUB: alu_r = {3'b000, bus.a} - {3'b000, bus.b};
      OP_MUL: alu_r = {3'b000, bus.a} * {3'b000, bus.b};
      OP_DIV: begin
        if (bus.b == 3'd0) alu_ovf = 1'b1;
        else alu_r = {3'b000, bus.a / bus.b};
      end
      OP_AND: alu_r = {3'b000, bus.a & bus.b};
      OP_OR:  alu_r = {3'b000, bus.a | bus.b};
      OP_XOR: alu_r = {3'b000, bus.a ^ bus.b};
      default: alu_r = '0;
    endcase
  end

  assign bus.result_in = alu_r;
  assign bus.zero_in   = (alu_r == 6'd0);
  assign bus.neg_in    = alu_r[2];
  assign bus.ovf_in    = alu_ovf;

  int   vectors     = 0;
  int   miscompares = 0;
  int   done_count  = 0;
  exp_t sb[$];

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives the buttons from a negedge, holds them, then releases long enough
  // for the release to be debounced too.
  task automatic apply_stimulus(input logic [2:0] sw_val, input logic enter,
                                input logic clear, input int hold);
    bus.sw        = sw_val;
    bus.btn_enter = enter;
    bus.btn_clear = clear;
    repeat (hold) @(negedge clk);
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // DONE monitor: pops the scoreboard, checks DONE lands two cycles after
  // the last GET_OP cycle, and that it never lasts more than one cycle.
  logic [2:0] step_d1 = 3'b000;
  logic [2:0] step_d2 = 3'b000;
  logic       done_d1 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        check_output("unexpected_done", 8'(bus.done), 8'd0);
      end else begin
        e = sb.pop_front();
        check_output("result_q", 8'(bus.result_q), 8'(e.result));
        check_output("zero_q", 8'(bus.zero_q), 8'(e.zero));
        check_output("neg_q", 8'(bus.neg_q), 8'(e.neg));
        check_output("ovf_q", 8'(bus.ovf_q), 8'(e.ovf));
        check_output("exec_step", 8'(step_d1), 8'(3'b000));
        check_output("press_step", 8'(step_d2), 8'(3'b100));
      end
    end
    if (done_d1) check_output("done_width", 8'(bus.done), 8'd0);
    step_d2 = step_d1;
    step_d1 = bus.step;
    done_d1 = (bus.done === 1'b1);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   done_before;
    logic found;

    rst           = 1'b1;
    bus.sw        = 3'd0;
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_a", 8'(bus.a), 8'd0);
    check_output("rst_b", 8'(bus.b), 8'd0);
    check_output("rst_op", 8'(bus.op), 8'd0);
    check_output("rst_result", 8'(bus.result_q), 8'd0);
    check_output("rst_zero", 8'(bus.zero_q), 8'd0);
    check_output("rst_neg", 8'(bus.neg_q), 8'd0);
    check_output("rst_ovf", 8'(bus.ovf_q), 8'd0);
    check_output("rst_done", 8'(bus.done), 8'd0);
    check_output("rst_step", 8'(bus.step), 8'(3'b001));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] 3 + 2");
    apply_stimulus(3'd3, 1'b1, 1'b0, 8);
    check_output("t2_a", 8'(bus.a), 8'd3);
    check_output("t2_step_b", 8'(bus.step), 8'(3'b010));
    apply_stimulus(3'd2, 1'b1, 1'b0, 8);
    check_output("t2_b", 8'(bus.b), 8'd2);
    check_output("t2_step_op", 8'(bus.step), 8'(3'b100));
    done_before = done_count;
    sb.push_back('{result: 6'd5, zero: 1'b0, neg: 1'b1, ovf: 1'b0});
    apply_stimulus(OP_ADD, 1'b1, 1'b0, 8);
    check_output("t2_done_pulses", 8'(done_count - done_before), 8'd1);
    check_output("t2_result_hold", 8'(bus.result_q), 8'd5);
    check_output("t2_step_show", 8'(bus.step), 8'(3'b000));

    $display("[TB] bounce rejection");
    apply_stimulus(3'd0, 1'b0, 1'b1, 8);
    check_output("t3_clear_result", 8'(bus.result_q), 8'd0);
    apply_stimulus(3'd7, 1'b1, 1'b0, 2);
    check_output("t3_bounce_a", 8'(bus.a), 8'd0);
    check_output("t3_bounce_step", 8'(bus.step), 8'(3'b001));
    apply_stimulus(3'd7, 1'b1, 1'b0, 6);
    check_output("t3_hold_a", 8'(bus.a), 8'd7);
    check_output("t3_hold_step", 8'(bus.step), 8'(3'b010));
    apply_stimulus(3'd4, 1'b1, 1'b0, 40);
    check_output("t3_long_b", 8'(bus.b), 8'd4);
    check_output("t3_long_step", 8'(bus.step), 8'(3'b100));

    $display("[TB] divide by zero");
    apply_stimulus(3'd0, 1'b0, 1'b1, 8);
    apply_stimulus(3'd5, 1'b1, 1'b0, 8);
    apply_stimulus(3'd0, 1'b1, 1'b0, 8);
    done_before = done_count;
    sb.push_back('{result: 6'd0, zero: 1'b1, neg: 1'b0, ovf: 1'b1});
    apply_stimulus(OP_DIV, 1'b1, 1'b0, 8);
    check_output("t4_done_pulses", 8'(done_count - done_before), 8'd1);
    check_output("t4_op", 8'(bus.op), 8'(OP_DIV));

    $display("[TB] chained operation from SHOW");
    apply_stimulus(3'd4, 1'b1, 1'b0, 8);
    check_output("chain_a", 8'(bus.a), 8'd4);
    check_output("chain_step", 8'(bus.step), 8'(3'b010));
    check_output("chain_ovf_kept", 8'(bus.ovf_q), 8'd1);
    apply_stimulus(3'd1, 1'b1, 1'b0, 8);
    sb.push_back('{result: 6'd5, zero: 1'b0, neg: 1'b1, ovf: 1'b0});
    apply_stimulus(OP_XOR, 1'b1, 1'b0, 8);
    check_output("chain_result", 8'(bus.result_q), 8'd5);

    $display("[TB] clear behaviour");
    apply_stimulus(3'd0, 1'b0, 1'b1, 8);
    apply_stimulus(3'd6, 1'b1, 1'b0, 8);
    check_output("t5_a", 8'(bus.a), 8'd6);
    apply_stimulus(3'd0, 1'b0, 1'b1, 8);
    check_output("t5_clear_a", 8'(bus.a), 8'd0);
    check_output("t5_clear_step", 8'(bus.step), 8'(3'b001));
    check_output("t5_clear_result", 8'(bus.result_q), 8'd0);
    apply_stimulus(3'd5, 1'b1, 1'b1, 8);
    check_output("t5_both_a", 8'(bus.a), 8'd0);
    check_output("t5_both_step", 8'(bus.step), 8'(3'b001));

    $display("[TB] reset during EXEC");
    apply_stimulus(3'd1, 1'b1, 1'b0, 8);
    apply_stimulus(3'd1, 1'b1, 1'b0, 8);
    done_before   = done_count;
    bus.sw        = OP_ADD;
    bus.btn_enter = 1'b1;
    found         = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.step == 3'b000) found = 1'b1;
    end
    check_output("t6_exec_reached", 8'(found), 8'd1);
    rst           = 1'b1;
    bus.btn_enter = 1'b0;
    @(negedge clk);
    check_output("t6_result", 8'(bus.result_q), 8'd0);
    check_output("t6_step", 8'(bus.step), 8'(3'b001));
    check_output("t6_done", 8'(bus.done), 8'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_output("t6_no_done", 8'(done_count - done_before), 8'd0);
    check_output("scoreboard_drained", 8'(sb.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
